// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA-1 front end: word/block geometry, the padding
// marker byte and the padder state encoding.
package sha1_pkg;

  localparam int unsigned SHA1_WORD_W  = 32;
  localparam int unsigned SHA1_BLOCK_W = 512;
  localparam int unsigned SHA1_WORDS   = SHA1_BLOCK_W / SHA1_WORD_W;

  localparam logic [7:0] SHA1_PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    S_FILL,       // collecting message words
    S_EMIT_DATA,  // full 16-word data block, message continues
    S_EMIT_PAD,   // block carrying the 0x80 byte (and length if it fits)
    S_EMIT_LEN    // trailing length-only block
  } pad_state_e;

endpackage

// File: rtl/sha1_msg_padder_if.sv
// Handshake bundle between a message source, the padder and the block consumer.
//   in_*    : 32-bit big-endian message word stream (valid/ready, last, nbytes)
//   block_* : 512-bit block stream (valid/ready, first/last markers)
// master = message source / block sink, slave = padder.
interface sha1_msg_padder_if;

  logic                               in_valid;
  logic                               in_ready;
  logic [sha1_pkg::SHA1_WORD_W-1:0]   in_data;
  logic                               in_last;
  logic [2:0]                         in_nbytes;

  logic                               block_valid;
  logic                               block_ready;
  logic [sha1_pkg::SHA1_BLOCK_W-1:0]  block;
  logic                               block_first;
  logic                               block_last;

  modport master (
    output in_valid, in_data, in_last, in_nbytes, block_ready,
    input  in_ready, block_valid, block, block_first, block_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, block_ready,
    output in_ready, block_valid, block, block_first, block_last
  );

endinterface

// File: rtl/sha1_pad_word.sv
// Combinational final-word formatter.
//   data_i   : last message word, first byte in [31:24]
//   nbytes_i : valid bytes (0..4, larger values act as 4)
//   word_o   : valid bytes kept, 0x80 at byte nbytes, remaining bytes zero
//   carry_o  : word was full, so the 0x80 byte belongs in the following word
module sha1_pad_word
  import sha1_pkg::*;
(
  input  logic [SHA1_WORD_W-1:0] data_i,
  input  logic [2:0]             nbytes_i,
  output logic [SHA1_WORD_W-1:0] word_o,
  output logic                   carry_o
);

  logic [2:0] nb;

  always_comb begin
    nb      = (nbytes_i > 3'd4) ? 3'd4 : nbytes_i;
    carry_o = (nb == 3'd4);
    word_o  = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (3'(b) < nb) begin
        word_o[31-8*b -: 8] = data_i[31-8*b -: 8];
      end else if (3'(b) == nb) begin
        word_o[31-8*b -: 8] = SHA1_PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: packs 32-bit big-endian words into 512-bit blocks and
// appends the 0x80 byte, zero fill and 64-bit bit length.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : word input stream and registered block output stream
//   LEN_W        : bit-length counter width (<= 64), zero-extended into the block
module sha1_msg_padder
  import sha1_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  sha1_msg_padder_if.slave bus
);

  pad_state_e              state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [LEN_W-1:0]        len_q, len_d, len_acc;
  logic                    pend_q, pend_d;
  logic                    first_q, first_d;
  logic                    ready_en_q;
  logic [SHA1_WORD_W-1:0]  buf_q [SHA1_WORDS];

  logic [SHA1_BLOCK_W-1:0] blk_q, blk_d;
  logic                    blk_valid_q, blk_valid_d;
  logic                    blk_first_q, blk_first_d;
  logic                    blk_last_q, blk_last_d;

  logic [SHA1_WORD_W-1:0]  pad_word;
  logic                    pad_carry;
  logic                    accept, hs;
  logic [5:0]              add_bits;
  logic [4:0]              pad_pos;
  logic                    single;
  logic [63:0]             len_acc64, len_q64;
  logic [SHA1_BLOCK_W-1:0] fill_blk, len_blk;

  sha1_pad_word u_pad_word (
    .data_i   (bus.in_data),
    .nbytes_i (bus.in_nbytes),
    .word_o   (pad_word),
    .carry_o  (pad_carry)
  );

  assign bus.in_ready    = (state_q == S_FILL) && ready_en_q;
  assign bus.block_valid = blk_valid_q;
  assign bus.block       = blk_q;
  assign bus.block_first = blk_first_q;
  assign bus.block_last  = blk_last_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign hs     = blk_valid_q && bus.block_ready;

  // A full last word (carry) contributes 32 bits, same as a non-last word.
  assign add_bits = (bus.in_last && !pad_carry) ? {bus.in_nbytes, 3'b000} : 6'd32;
  assign len_acc  = len_q + LEN_W'(add_bits);
  // Word index holding the 0x80 byte; 16 means it spills into a length block.
  assign pad_pos  = {1'b0, idx_q} + {4'b0000, pad_carry};
  assign single   = (pad_pos <= 5'd13);

  // Block formed by the word being accepted now plus the buffered words.
  always_comb begin
    len_acc64              = '0;
    len_acc64[LEN_W-1:0]   = len_acc;
    fill_blk               = '0;
    for (int unsigned i = 0; i < SHA1_WORDS; i++) begin
      if (i < 32'(idx_q)) begin
        fill_blk[SHA1_BLOCK_W-1-SHA1_WORD_W*i -: SHA1_WORD_W] = buf_q[4'(i)];
      end else if (i == 32'(idx_q)) begin
        fill_blk[SHA1_BLOCK_W-1-SHA1_WORD_W*i -: SHA1_WORD_W] =
            bus.in_last ? pad_word : bus.in_data;
      end else if (bus.in_last && pad_carry && (i == 32'(pad_pos))) begin
        fill_blk[SHA1_BLOCK_W-1-SHA1_WORD_W*i -: SHA1_WORD_W] = {SHA1_PAD_BYTE, 24'h0};
      end
    end
    if (bus.in_last && single) begin
      fill_blk[63:0] = len_acc64;
    end
  end

  // Trailing block when the length did not fit beside the data.
  always_comb begin
    len_q64            = '0;
    len_q64[LEN_W-1:0] = len_q;
    len_blk            = '0;
    len_blk[SHA1_BLOCK_W-1 -: SHA1_WORD_W] = pend_q ? {SHA1_PAD_BYTE, 24'h0} : '0;
    len_blk[63:0]      = len_q64;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    pend_d      = pend_q;
    first_d     = first_q;
    blk_d       = blk_q;
    blk_valid_d = blk_valid_q;
    blk_first_d = blk_first_q;
    blk_last_d  = blk_last_q;

    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          len_d = len_acc;
          if (bus.in_last) begin
            idx_d       = '0;
            pend_d      = pad_carry && (idx_q == 4'd15);
            blk_d       = fill_blk;
            blk_valid_d = 1'b1;
            blk_first_d = first_q;
            blk_last_d  = single;
            state_d     = S_EMIT_PAD;
          end else begin
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15) begin
              blk_d       = fill_blk;
              blk_valid_d = 1'b1;
              blk_first_d = first_q;
              blk_last_d  = 1'b0;
              state_d     = S_EMIT_DATA;
            end
          end
        end
      end
      S_EMIT_DATA: begin
        if (hs) begin
          blk_valid_d = 1'b0;
          first_d     = 1'b0;
          state_d     = S_FILL;
        end
      end
      S_EMIT_PAD: begin
        if (hs) begin
          if (blk_last_q) begin
            blk_valid_d = 1'b0;
            first_d     = 1'b1;
            idx_d       = '0;
            len_d       = '0;
            pend_d      = 1'b0;
            state_d     = S_FILL;
          end else begin
            // Next block follows without a bubble.
            first_d     = 1'b0;
            blk_d       = len_blk;
            blk_first_d = 1'b0;
            blk_last_d  = 1'b1;
            state_d     = S_EMIT_LEN;
          end
        end
      end
      S_EMIT_LEN: begin
        if (hs) begin
          blk_valid_d = 1'b0;
          first_d     = 1'b1;
          idx_d       = '0;
          len_d       = '0;
          pend_d      = 1'b0;
          state_d     = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FILL;
      idx_q       <= '0;
      len_q       <= '0;
      pend_q      <= 1'b0;
      first_q     <= 1'b1;
      ready_en_q  <= 1'b0;
      blk_q       <= '0;
      blk_valid_q <= 1'b0;
      blk_first_q <= 1'b0;
      blk_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      pend_q      <= pend_d;
      first_q     <= first_d;
      ready_en_q  <= 1'b1;
      blk_q       <= blk_d;
      blk_valid_q <= blk_valid_d;
      blk_first_q <= blk_first_d;
      blk_last_q  <= blk_last_d;
    end
  end

  // Buffer contents are qualified by idx_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q[idx_q] <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Self-checking bench for sha1_msg_padder. Expected blocks come from a byte-level
// FIPS 180-4 padding model (append 0x80, zero fill to 56 mod 64, 64-bit length).
module tb_sha1_msg_padder;

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sha1_msg_padder_if bus ();

  sha1_msg_padder #(.LEN_W(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [511:0] exp_blk [$];
  logic         exp_first [$];
  logic         exp_last [$];
  logic [511:0] rx_blk [$];
  logic         rx_first [$];
  logic         rx_last [$];
  logic [31:0]  wq [$];
  logic         lq [$];
  logic [2:0]   nq [$];

  task automatic model_msg(input bq_t msg);
    bq_t p;
    logic [63:0] bl;
    logic [511:0] v;
    int nblk;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      v = '0;
      for (int j = 0; j < 64; j++) v[511-8*j -: 8] = p[64*b+j];
      exp_blk.push_back(v);
      exp_first.push_back(b == 0);
      exp_last.push_back(b == nblk - 1);
    end
  endtask

  // Build the word stream for msg and the expected blocks.
  task automatic prep_msg(input bq_t msg, input bit alt, input bit rawnb);
    int L, nw, nb;
    logic [31:0] d;
    exp_blk.delete(); exp_first.delete(); exp_last.delete();
    rx_blk.delete(); rx_first.delete(); rx_last.delete();
    wq.delete(); lq.delete(); nq.delete();
    model_msg(msg);
    L  = msg.size();
    nw = (L == 0) ? 1 : (L + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      d  = $urandom;
      nb = 0;
      for (int b = 0; b < 4; b++) begin
        if (4*w + b < L) begin
          d[31-8*b -: 8] = msg[4*w+b];
          nb++;
        end
      end
      wq.push_back(d);
      lq.push_back(w == nw - 1);
      if (w == nw - 1) nq.push_back((nb == 4 && rawnb) ? 3'($urandom_range(5, 7)) : 3'(nb));
      else nq.push_back(3'($urandom));
    end
    // Alternative ending: full last data word followed by an empty last word.
    if (alt && L > 0 && L % 4 == 0) begin
      lq[nw-1] = 1'b0;
      wq.push_back($urandom);
      lq.push_back(1'b1);
      nq.push_back(3'd0);
    end
  endtask

  task automatic drive_msg(input int n, input bit gaps);
    int i = 0;
    int cyc = 0;
    while (i < n) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
      end else begin
        bus.in_valid  = 1'b1;
        bus.in_data   = wq[i];
        bus.in_last   = lq[i];
        bus.in_nbytes = nq[i];
        if (bus.in_ready) i++;
      end
      cyc++;
      if (cyc > 4000) begin
        checks++; errors++;
        $display("FAIL drive_timeout sent %0d of %0d words", i, n);
        break;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic collect(input bit rnd_ready);
    int cyc = 0;
    while (rx_blk.size() < exp_blk.size()) begin
      @(negedge clk);
      bus.block_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (bus.block_valid && bus.block_ready) begin
        rx_blk.push_back(bus.block);
        rx_first.push_back(bus.block_first);
        rx_last.push_back(bus.block_last);
      end
      cyc++;
      if (cyc > 4000) begin
        checks++; errors++;
        $display("FAIL collect_timeout got %0d blocks want %0d", rx_blk.size(), exp_blk.size());
        break;
      end
    end
    @(negedge clk);
    bus.block_ready = 1'b0;
  endtask

  task automatic run_msg(input bq_t msg, input bit alt, input bit rawnb, input bit gaps,
                         input bit rnd_ready);
    prep_msg(msg, alt, rawnb);
    fork
      drive_msg(wq.size(), gaps);
      collect(rnd_ready);
    join
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.in_nbytes = '0;
    bus.block_ready = 1'b0;
    reset_n = 1'b0;
    #12;
    checks++;
    if (bus.block_valid !== 1'b0 || bus.block !== 512'b0 || bus.block_first !== 1'b0 ||
        bus.block_last !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v%b f%b l%b r%b blk_nonzero=%0b want all 0",
               bus.block_valid, bus.block_first, bus.block_last, bus.in_ready, |bus.block);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_first_cycle got %b want 0", bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_after got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_vectors();
    bq_t msg;
    logic [511:0] lit;
    string tag;
    for (int v = 0; v < 4; v++) begin
      msg = {};
      case (v)
        0: begin msg = {8'h61, 8'h62, 8'h63}; tag = "abc"; end
        1: tag = "empty";
        2: begin repeat (56) msg.push_back(8'($urandom)); tag = "len56"; end
        default: begin repeat (64) msg.push_back(8'($urandom)); tag = "len64"; end
      endcase
      run_msg(msg, 1'b0, 1'b0, v[0], 1'b0);
      checks++;
      if (rx_blk.size() != exp_blk.size()) begin
        errors++;
        $display("FAIL %s_count got %0d want %0d", tag, rx_blk.size(), exp_blk.size());
      end
      for (int k = 0; k < rx_blk.size() && k < exp_blk.size(); k++) begin
        checks++;
        if (rx_blk[k] !== exp_blk[k] || rx_first[k] !== exp_first[k] ||
            rx_last[k] !== exp_last[k]) begin
          errors++;
          $display("FAIL %s_blk%0d got %h f%b l%b want %h f%b l%b", tag, k, rx_blk[k],
                   rx_first[k], rx_last[k], exp_blk[k], exp_first[k], exp_last[k]);
        end
      end
      lit = '0;
      case (v)
        0: begin
          lit[511 -: 32] = 32'h61626380;
          lit[31:0]      = 32'h00000018;
          checks++;
          if (rx_blk.size() != 1 || rx_blk[0] !== lit || rx_first[0] !== 1'b1 ||
              rx_last[0] !== 1'b1) begin
            errors++; $display("FAIL abc_literal got %h want %h", rx_blk[0], lit);
          end
        end
        1: begin
          lit[511 -: 32] = 32'h80000000;
          checks++;
          if (rx_blk.size() != 1 || rx_blk[0] !== lit || rx_first[0] !== 1'b1 ||
              rx_last[0] !== 1'b1) begin
            errors++; $display("FAIL empty_literal got %h want %h", rx_blk[0], lit);
          end
        end
        2: begin
          lit[31:0] = 32'h000001C0;
          checks++;
          if (rx_blk.size() != 2 || rx_blk[0][63:0] !== {32'h80000000, 32'h0} ||
              rx_last[0] !== 1'b0 || rx_blk[1] !== lit || rx_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL len56_literal got tail %h / %h want %h / %h", rx_blk[0][63:0],
                     rx_blk[1], {32'h80000000, 32'h0}, lit);
          end
        end
        default: begin
          lit[511 -: 32] = 32'h80000000;
          lit[31:0]      = 32'h00000200;
          checks++;
          if (rx_blk.size() != 2 || rx_blk[1] !== lit || rx_first[1] !== 1'b0 ||
              rx_last[1] !== 1'b1 || rx_last[0] !== 1'b0) begin
            errors++; $display("FAIL len64_literal got %h want %h", rx_blk[1], lit);
          end
        end
      endcase
    end
  endtask

  task automatic test_backpressure();
    bq_t msg;
    logic [511:0] snap;
    logic sf, sl;
    int cyc;
    msg = {};
    repeat (56) msg.push_back(8'($urandom));
    prep_msg(msg, 1'b0, 1'b0);
    bus.block_ready = 1'b0;
    fork
      drive_msg(wq.size(), 1'b0);
      begin
        cyc = 0;
        while (!bus.block_valid && cyc < 500) begin
          @(negedge clk);
          cyc++;
        end
        checks++;
        if (bus.block_valid !== 1'b1) begin
          errors++; $display("FAIL bp_valid got %b want 1", bus.block_valid);
        end
        snap = bus.block; sf = bus.block_first; sl = bus.block_last;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checks++;
          if (bus.block !== snap || bus.block_first !== sf || bus.block_last !== sl ||
              bus.block_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d got v%b r%b f%b l%b changed=%b want v1 r0 stable", c,
                     bus.block_valid, bus.in_ready, bus.block_first, bus.block_last,
                     bus.block !== snap);
          end
        end
      end
    join
    collect(1'b0);
    checks++;
    if (rx_blk.size() != exp_blk.size()) begin
      errors++; $display("FAIL bp_count got %0d want %0d", rx_blk.size(), exp_blk.size());
    end
    for (int k = 0; k < rx_blk.size() && k < exp_blk.size(); k++) begin
      checks++;
      if (rx_blk[k] !== exp_blk[k] || rx_first[k] !== exp_first[k] ||
          rx_last[k] !== exp_last[k]) begin
        errors++;
        $display("FAIL bp_blk%0d got %h f%b l%b want %h f%b l%b", k, rx_blk[k], rx_first[k],
                 rx_last[k], exp_blk[k], exp_first[k], exp_last[k]);
      end
    end
    msg = {8'h61, 8'h62, 8'h63};
    run_msg(msg, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rx_blk.size() != 1 || rx_first[0] !== 1'b1 || rx_blk[0] !== exp_blk[0]) begin
      errors++;
      $display("FAIL bp_next_first got n%0d f%b want n1 f1", rx_blk.size(), rx_first[0]);
    end
  endtask

  task automatic test_random();
    bq_t msg;
    string tag;
    bit alt, rawnb, gaps, rnd;
    for (int m = 0; m < 25; m++) begin
      msg = {};
      repeat ($urandom_range(0, 140)) msg.push_back(8'($urandom));
      alt = 1'($urandom); rawnb = 1'($urandom); gaps = 1'($urandom); rnd = 1'($urandom);
      tag = $sformatf("rand%0d_len%0d", m, msg.size());
      run_msg(msg, alt, rawnb, gaps, rnd);
      checks++;
      if (rx_blk.size() != exp_blk.size()) begin
        errors++;
        $display("FAIL %s_count got %0d want %0d", tag, rx_blk.size(), exp_blk.size());
      end
      for (int k = 0; k < rx_blk.size() && k < exp_blk.size(); k++) begin
        checks++;
        if (rx_blk[k] !== exp_blk[k] || rx_first[k] !== exp_first[k] ||
            rx_last[k] !== exp_last[k]) begin
          errors++;
          $display("FAIL %s_blk%0d got %h f%b l%b want %h f%b l%b", tag, k, rx_blk[k],
                   rx_first[k], rx_last[k], exp_blk[k], exp_first[k], exp_last[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bq_t msg;
    logic [511:0] lit;
    msg = {};
    repeat (40) msg.push_back(8'($urandom));
    prep_msg(msg, 1'b0, 1'b0);
    drive_msg(7, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.block_valid !== 1'b0 || bus.block !== 512'b0 || bus.block_first !== 1'b0 ||
        bus.block_last !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs got v%b f%b l%b r%b want all 0", bus.block_valid,
               bus.block_first, bus.block_last, bus.in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    msg = {8'h61, 8'h62, 8'h63};
    run_msg(msg, 1'b0, 1'b0, 1'b0, 1'b0);
    lit = '0;
    lit[511 -: 32] = 32'h61626380;
    lit[31:0]      = 32'h00000018;
    checks++;
    if (rx_blk.size() != 1 || rx_blk[0] !== lit || rx_first[0] !== 1'b1 ||
        rx_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_abc got n%0d %h want %h", rx_blk.size(), rx_blk[0], lit);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
